ln_affine_stage: RTL and testbench
==================================

LN_AFFINE_STAGE -- requirements
Module: ln_affine_stage

Interface
REQ-001 SHALL have parameter DAT_DW, default 16: lane data width, signed two's complement.
REQ-002 SHALL have parameter TOUT, default 32: lanes per beat.
REQ-003 SHALL have parameter CH_AW, default 7: wt/bias buffer address width, i.e. channel-group address bits.
REQ-004 SHALL have parameter FRAC, default 8 (FRAC ≥ 1): fractional bits of wt.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle job launch pulse.
REQ-008 SHALL have port CH_in_div_Tout, input, CH_AW bits: channel groups per row, valid range 1..2^CH_AW-1.
REQ-009 SHALL have port row_num, input, 16 bits: rows (tokens) per job, ≥1.
REQ-010 SHALL have ports norm_vld (in, 1), norm_rdy (out, 1) and norm_pd (in, TOUT*DAT_DW): normalized input stream; lane i = bits [i*DAT_DW +: DAT_DW].
REQ-011 SHALL have ports rd_wt_en (out, 1), rd_wt_addr (out, CH_AW), rd_wt_vld (in, 1) and wt_rd_dat (in, TOUT*DAT_DW): weight buffer read port.
REQ-012 SHALL have ports rd_bias_en (out, 1), rd_bias_addr (out, CH_AW), rd_bias_vld (in, 1) and bias_rd_dat (in, TOUT*DAT_DW): bias buffer read port.
REQ-013 SHALL have ports out_vld (out, 1), out_rdy (in, 1) and out_pd (out, TOUT*DAT_DW): affine result stream.
REQ-014 SHALL have ports busy (out, 1) and done (out, 1): job busy level and one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN: IDLE→RUN on start; RUN→DRAIN on acceptance of the last input beat; DRAIN→IDLE on acceptance of the last output beat, with done=1 in that cycle.
REQ-016 SHALL ignore start outside IDLE; SHALL latch CH_in_div_Tout and row_num on the accepted start.
REQ-017 SHALL drive busy=1 in RUN and DRAIN, 0 in IDLE.
REQ-018 SHALL count an input beat as accepted when norm_vld & norm_rdy; norm_rdy = (state==RUN) & (fifo_count + inflight < 4).
REQ-019 SHALL maintain ch_cnt (0..CH_in_div_Tout-1) and row_cnt (0..row_num-1) on input acceptance; ch_cnt wraps to 0 and row_cnt increments at ch_cnt==CH_in_div_Tout-1; the last beat is ch_cnt==CH_in_div_Tout-1 & row_cnt==row_num-1.
REQ-020 SHALL, in the acceptance cycle, drive rd_wt_en=rd_bias_en=1 and rd_wt_addr=rd_bias_addr=ch_cnt, and register norm_pd alongside; both enables SHALL be 0 otherwise.
REQ-021 SHALL take the buffer read latency as exactly 1 cycle: the returned wt/bias are paired with the registered input in the cycle rd_wt_vld & rd_bias_vld is high.
REQ-022 SHALL compute per lane: p = x*w (2*DAT_DW signed); r = (p + 2^(FRAC-1)) >>> FRAC; s = r + b (2*DAT_DW+1 bits); out = s saturated to [-2^(DAT_DW-1), 2^(DAT_DW-1)-1].
REQ-023 SHALL register s-saturation into a 4-entry output FIFO one cycle after read return; inflight counts beats accepted but not yet written to the FIFO (0..2).
REQ-024 SHALL have out_vld = FIFO non-empty and out_pd = FIFO head; the head pops on out_vld & out_rdy; out_pd SHALL hold stable while out_vld & ~out_rdy.
REQ-025 SHALL give out_vld latency 3 cycles from input acceptance with an empty FIFO and out_rdy=1: accept at T, read return at T+1, FIFO write at T+2 edge, out_vld=1 at T+3.
REQ-026 SHALL sustain 1 beat/cycle with out_rdy held 1; a simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-027 SHALL never overflow the FIFO: the credit rule in REQ-018 guarantees fifo_count + inflight ≤ 4.
REQ-028 SHALL leave rd_wt_vld/rd_bias_vld arriving without a matching request ignored.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, return to IDLE and clear ch_cnt, row_cnt, inflight and the FIFO, with norm_rdy, out_vld, rd_wt_en, rd_bias_en, busy and done all 0 and the address outputs 0.
REQ-030 SHALL abort a job on reset mid-RUN or mid-DRAIN with no done pulse; in-flight data is discarded.

Verification
REQ-031 SHALL be verified by: FRAC=8, wt=0x0100, bias=0x0010, x=0x0200 on all lanes → out 0x0210 at T+3.
REQ-032 SHALL be verified by: x=0x7FFF, wt=0x0200, bias=0 → 0x7FFF; x=0x8000, wt=0x0200 → 0x8000 (saturation).
REQ-033 SHALL be verified by: CH_in_div_Tout=3, row_num=2, continuous input → rd addresses 0,1,2,0,1,2; done exactly once, on the 6th output pop.
REQ-034 SHALL be verified by: out_rdy=0 for 10 cycles with norm_vld=1 → exactly 4 beats accepted, norm_rdy=0 afterwards; on release, all beats emerge in order with none lost.
REQ-035 SHALL be verified by: rst=1 during DRAIN with 2 entries in the FIFO → next cycle out_vld=0, busy=0, no done; a fresh start then runs normally.
REQ-036 SHALL be verified by: start pulsed during RUN → ignored; counts and done unchanged.

Source files
------------

// File: rtl/ln_affine_stage.sv
// Per-lane affine stage: out = sat(round(x*w >> FRAC) + b) over a channel-group
// stream, with 1-cycle wt/bias buffer reads and a 4-deep credit-guarded output FIFO.
//
// state | meaning
// IDLE  | waiting for start; inputs not accepted
// RUN   | accepting input beats, issuing wt/bias reads
// DRAIN | all inputs accepted; emptying pipeline and FIFO
module ln_affine_stage #(
    parameter int DAT_DW = 16,
    parameter int TOUT   = 32,
    parameter int CH_AW  = 7,
    parameter int FRAC   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CH_AW-1:0]         CH_in_div_Tout,
    input  logic [15:0]              row_num,
    input  logic                     norm_vld,
    output logic                     norm_rdy,
    input  logic [TOUT*DAT_DW-1:0]   norm_pd,
    output logic                     rd_wt_en,
    output logic [CH_AW-1:0]         rd_wt_addr,
    input  logic                     rd_wt_vld,
    input  logic [TOUT*DAT_DW-1:0]   wt_rd_dat,
    output logic                     rd_bias_en,
    output logic [CH_AW-1:0]         rd_bias_addr,
    input  logic                     rd_bias_vld,
    input  logic [TOUT*DAT_DW-1:0]   bias_rd_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [TOUT*DAT_DW-1:0]   out_pd,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = TOUT*DAT_DW;
    localparam int MW = 2*DAT_DW;
    localparam int SW = 2*DAT_DW+1;

    localparam logic signed [SW-1:0] RND     = SW'(1) << (FRAC-1);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (DAT_DW-1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CH_AW-1:0] ch_lat, ch_cnt;
    logic [15:0]      row_lat, row_cnt;
    logic             accept, ch_last, row_last, in_last;

    logic             s1_vld, s2_vld, rd_ret;
    logic [PW-1:0]    s1_pd, s2_pd, sat_pd;

    logic [PW-1:0]    fifo_mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       fifo_count;
    logic [1:0]       inflight;
    logic             push, pop, last_pop;

    // Beats accepted but not yet written to the FIFO live in s1/s2.
    assign inflight = {1'b0, s1_vld} + {1'b0, s2_vld};
    assign norm_rdy = (state == RUN) && ((fifo_count + {1'b0, inflight}) < 3'd4);
    assign accept   = norm_vld & norm_rdy;

    assign ch_last  = (ch_cnt == ch_lat - CH_AW'(1));
    assign row_last = (row_cnt == row_lat - 16'd1);
    assign in_last  = accept & ch_last & row_last;

    assign rd_wt_en     = accept;
    assign rd_bias_en   = accept;
    assign rd_wt_addr   = accept ? ch_cnt : '0;
    assign rd_bias_addr = accept ? ch_cnt : '0;

    // Returns without an outstanding request are dropped here.
    assign rd_ret = s1_vld & rd_wt_vld & rd_bias_vld;

    assign push     = s2_vld;
    assign out_vld  = (fifo_count != 3'd0);
    assign out_pd   = fifo_mem[rd_ptr];
    assign pop      = out_vld & out_rdy;
    assign last_pop = pop && (fifo_count == 3'd1) && !s1_vld && !s2_vld;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_pop) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ch_lat  <= '0;
            row_lat <= '0;
            ch_cnt  <= '0;
            row_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                ch_lat  <= CH_in_div_Tout;
                row_lat <= row_num;
                ch_cnt  <= '0;
                row_cnt <= '0;
            end else if (accept) begin
                if (ch_last) begin
                    ch_cnt  <= '0;
                    row_cnt <= row_last ? 16'd0 : row_cnt + 16'd1;
                end else begin
                    ch_cnt <= ch_cnt + CH_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
            s2_vld <= rd_ret;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) s1_pd <= norm_pd;
        if (rd_ret) s2_pd <= sat_pd;
    end

    genvar gi;
    generate
        for (gi = 0; gi < TOUT; gi++) begin : g_lane
            logic signed [DAT_DW-1:0] x, w, b;
            logic signed [MW-1:0]     p;
            logic signed [SW-1:0]     r, s;

            assign x = s1_pd[gi*DAT_DW +: DAT_DW];
            assign w = wt_rd_dat[gi*DAT_DW +: DAT_DW];
            assign b = bias_rd_dat[gi*DAT_DW +: DAT_DW];
            assign p = MW'(x) * MW'(w);
            // Round half up, then arithmetic shift (floor) out the fraction.
            assign r = (SW'(p) + RND) >>> FRAC;
            assign s = r + SW'(b);
            assign sat_pd[gi*DAT_DW +: DAT_DW] =
                (s > SAT_MAX) ? SAT_MAX[DAT_DW-1:0] :
                (s < SAT_MIN) ? SAT_MIN[DAT_DW-1:0] :
                                s[DAT_DW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= s2_pd;
    end

endmodule

// File: tb/tb_ln_affine_stage.sv
// Bench for ln_affine_stage: directed jobs, buffer responder, and a per-cycle
// arithmetic/queue model of the affine stream.
module tb_ln_affine_stage;
    localparam int DW    = 16;
    localparam int TOUT  = 32;
    localparam int CH_AW = 7;
    localparam int FRAC  = 8;
    localparam int PW    = DW*TOUT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CH_AW-1:0] CH_in_div_Tout = '0;
    logic [15:0]      row_num = '0;
    logic             norm_vld = 1'b0;
    logic             norm_rdy;
    logic [PW-1:0]    norm_pd = '0;
    logic             rd_wt_en, rd_bias_en;
    logic [CH_AW-1:0] rd_wt_addr, rd_bias_addr;
    logic             rd_wt_vld = 1'b0, rd_bias_vld = 1'b0;
    logic [PW-1:0]    wt_rd_dat = '0, bias_rd_dat = '0;
    logic             out_vld;
    logic             out_rdy = 1'b1;
    logic [PW-1:0]    out_pd;
    logic             busy, done;

    ln_affine_stage #(.DAT_DW(DW), .TOUT(TOUT), .CH_AW(CH_AW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .CH_in_div_Tout(CH_in_div_Tout), .row_num(row_num),
        .norm_vld(norm_vld), .norm_rdy(norm_rdy), .norm_pd(norm_pd),
        .rd_wt_en(rd_wt_en), .rd_wt_addr(rd_wt_addr), .rd_wt_vld(rd_wt_vld), .wt_rd_dat(wt_rd_dat),
        .rd_bias_en(rd_bias_en), .rd_bias_addr(rd_bias_addr), .rd_bias_vld(rd_bias_vld),
        .bias_rd_dat(bias_rd_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Weight/bias buffers with exactly one cycle of read latency.
    logic [PW-1:0] wt_mem   [128];
    logic [PW-1:0] bias_mem [128];
    logic          spur = 1'b0;

    always @(posedge clk) begin
        rd_wt_vld   <= rd_wt_en | spur;
        rd_bias_vld <= rd_bias_en | spur;
        wt_rd_dat   <= wt_mem[rd_wt_addr];
        bias_rd_dat <= bias_mem[rd_bias_addr];
    end

    function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] xu, input logic [DW-1:0] wu,
                                                 input logic [DW-1:0] bu);
        longint x, w, b, n, d, r, s, hi, lo;
        x  = longint'($signed(xu));
        w  = longint'($signed(wu));
        b  = longint'($signed(bu));
        d  = longint'(1) << FRAC;
        n  = x*w + d/2;
        r  = n / d;
        if (n < 0 && (n % d) != 0) r = r - 1;
        s  = r + b;
        hi = (longint'(1) << (DW-1)) - 1;
        lo = -hi - 1;
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        return s[DW-1:0];
    endfunction

    function automatic logic [PW-1:0] model_vec(input logic [PW-1:0] x, input logic [PW-1:0] w,
                                                input logic [PW-1:0] b);
        logic [PW-1:0] v;
        v = '0;
        for (int l = 0; l < TOUT; l++)
            v[l*DW +: DW] = model_lane(x[l*DW +: DW], w[l*DW +: DW], b[l*DW +: DW]);
        return v;
    endfunction

    function automatic logic [PW-1:0] gen_x(input int beat, input int seed);
        logic [PW-1:0] v;
        v = '0;
        for (int l = 0; l < TOUT; l++)
            v[l*DW +: DW] = 16'(((beat+1)*(l*2654+101) + seed*7919) ^ (beat << 11));
        return v;
    endfunction

    // Scoreboard: expected results queue and job bookkeeping.
    logic [PW-1:0] exp_q[$];
    int            addr_log[$];
    bit            exp_busy = 1'b0;
    int            exp_ch, exp_row, job_ch, job_total, n_pop;
    int            n_done = 0;

    always @(negedge clk) begin : monitor
        bit exp_done;
        if (rst) begin
            exp_q.delete();
            exp_busy = 1'b0;
        end else begin
            chk("busy", busy, exp_busy);
            if (!exp_busy) chk("norm_rdy_idle", norm_rdy, 0);
            if (norm_vld && norm_rdy) begin
                chk("rd_en", {rd_wt_en, rd_bias_en}, 2'b11);
                chk("rd_wt_addr", rd_wt_addr, exp_ch);
                chk("rd_bias_addr", rd_bias_addr, exp_ch);
                addr_log.push_back(int'(rd_wt_addr));
                exp_q.push_back(model_vec(norm_pd, wt_mem[exp_ch], bias_mem[exp_ch]));
                chk("credit", exp_q.size() <= 4, 1);
                exp_ch++;
                if (exp_ch == job_ch) begin
                    exp_ch = 0;
                    exp_row++;
                end
            end else begin
                chk("rd_en_quiet", {rd_wt_en, rd_bias_en}, 2'b00);
            end
            exp_done = 1'b0;
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", out_vld, 0);
                end else begin
                    chk("out_pd", out_pd, exp_q[0]);
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                        exp_done = exp_busy && (n_pop == job_total);
                    end
                end
            end
            chk("done", done, exp_done);
            if (done) n_done++;
            if (!exp_busy && start) begin
                exp_busy  = 1'b1;
                job_ch    = int'(CH_in_div_Tout);
                job_total = int'(CH_in_div_Tout) * int'(row_num);
                exp_ch    = 0;
                exp_row   = 0;
                n_pop     = 0;
            end else if (exp_done) begin
                exp_busy = 1'b0;
            end
        end
    end

    bit bp_en = 1'b0;
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic start_job(input int ch, input int rows);
        CH_in_div_Tout = CH_AW'(ch);
        row_num        = 16'(rows);
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
    endtask

    task automatic send_beats(input int n, input int base, input int seed, input int pulse_at,
                              output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc      = 1'b0;
            norm_pd  = gen_x(base + i, seed);
            norm_vld = 1'b1;
            if (i == pulse_at) begin
                start          = 1'b1;
                CH_in_div_Tout = 7'd5;
                row_num        = 16'd9;
            end
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = norm_rdy;
                if (!acc) stalls++;
                @(posedge clk); #1;
                start = 1'b0;
            end
            chk("send_accept", acc, 1);
        end
        norm_vld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk({name, "_done_seen"}, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output logic [PW-1:0] pd, output logic dn, output bit ok);
        ok = 1'b0;
        pd = '0;
        dn = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (out_vld) begin
                ok = 1'b1;
                pd = out_pd;
                dn = done;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [PW-1:0] v, pd;
        logic          dn;
        bit            ok;
        int            st, d0, nacc;
        int            exp_addr3[6];
        int            exp_addr2[4];
        exp_addr3 = '{0, 1, 2, 0, 1, 2};
        exp_addr2 = '{0, 1, 0, 1};

        for (int c = 0; c < 128; c++) begin
            for (int l = 0; l < TOUT; l++) begin
                wt_mem[c][l*DW +: DW]   = 16'(((c+1)*(l+3)*149) ^ (l << 9));
                bias_mem[c][l*DW +: DW] = 16'(c*1000 - l*700);
            end
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_norm_rdy", norm_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_rd_en", {rd_wt_en, rd_bias_en}, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", {rd_wt_addr, rd_bias_addr}, 0);
        @(posedge clk); #1;

        // Pin the model on hand-computed lanes.
        chk("model_basic", model_lane(16'h0200, 16'h0100, 16'h0010), 16'h0210);
        chk("model_sat_hi", model_lane(16'h7FFF, 16'h0200, 16'h0000), 16'h7FFF);
        chk("model_sat_lo", model_lane(16'h8000, 16'h0200, 16'h0000), 16'h8000);
        chk("model_rnd_up", model_lane(16'h0001, 16'h0080, 16'h0000), 16'h0001);
        chk("model_rnd_neg", model_lane(16'hFFFD, 16'h0040, 16'h0000), 16'hFFFF);
        chk("model_rnd_3", model_lane(16'h0003, 16'h0080, 16'h0000), 16'h0002);

        // Basic value and 3-cycle latency.
        wt_mem[0]   = {TOUT{16'h0100}};
        bias_mem[0] = {TOUT{16'h0010}};
        start_job(1, 1);
        norm_pd  = {TOUT{16'h0200}};
        norm_vld = 1'b1;
        @(negedge clk); chk("lat_accept", norm_rdy, 1);
        @(posedge clk); #1 norm_vld = 1'b0;
        @(negedge clk); chk("lat_t1", out_vld, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_t2", out_vld, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_t3", out_vld, 1);
        v = {TOUT{16'h0210}};
        chk("lat_value", out_pd, v);
        chk("lat_done", done, 1);
        @(posedge clk); #1;

        // Saturation both directions.
        wt_mem[0]   = {TOUT{16'h0200}};
        bias_mem[0] = '0;
        for (int l = 0; l < TOUT; l++) v[l*DW +: DW] = (l % 2 == 0) ? 16'h7FFF : 16'h8000;
        start_job(1, 1);
        norm_pd  = v;
        norm_vld = 1'b1;
        @(negedge clk); chk("sat_accept", norm_rdy, 1);
        @(posedge clk); #1 norm_vld = 1'b0;
        wait_out(pd, dn, ok);
        chk("sat_seen", ok, 1);
        chk("sat_value", pd, v);
        chk("sat_done", dn, 1);

        // Address sequencing, throughput, single done.
        addr_log.delete();
        d0 = n_done;
        start_job(3, 2);
        send_beats(6, 0, 3, -1, st);
        chk("tput_stalls", st, 0);
        wait_done("seq");
        chk("seq_addr_count", addr_log.size(), 6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("seq_addr", addr_log[i], exp_addr3[i]);
        chk("seq_done_once", n_done - d0, 1);

        // Backpressure: credit stops at 4, nothing lost on release.
        out_rdy = 1'b0;
        start_job(2, 4);
        nacc     = 0;
        norm_vld = 1'b1;
        norm_pd  = gen_x(0, 5);
        repeat (10) begin
            @(negedge clk);
            if (norm_rdy) nacc++;
            @(posedge clk); #1;
            norm_pd = gen_x(nacc, 5);
        end
        chk("bp_accepted", nacc, 4);
        @(negedge clk); chk("bp_rdy_low", norm_rdy, 0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        send_beats(4, 4, 5, -1, st);
        wait_done("bp");

        // Reset during DRAIN with two FIFO entries.
        d0      = n_done;
        out_rdy = 1'b0;
        start_job(1, 2);
        send_beats(2, 0, 9, -1, st);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk); chk("drain_pre_vld", out_vld, 1); chk("drain_pre_busy", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("drain_rst_vld", out_vld, 0);
        chk("drain_rst_busy", busy, 0);
        chk("drain_rst_done", done, 0);
        @(posedge clk); #1;
        chk("drain_no_done", n_done - d0, 0);
        out_rdy = 1'b1;
        start_job(1, 1);
        send_beats(1, 0, 11, -1, st);
        wait_done("after_rst");

        // Start pulsed mid-RUN must be ignored.
        addr_log.delete();
        d0 = n_done;
        start_job(2, 2);
        send_beats(4, 0, 13, 1, st);
        wait_done("ign_start");
        chk("ign_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("ign_addr", addr_log[i], exp_addr2[i]);
        chk("ign_done_once", n_done - d0, 1);
        chk("ign_idle", busy, 0);

        // Unrequested read returns are ignored.
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (4) begin
            @(negedge clk); chk("spur_out_vld", out_vld, 0);
        end
        @(posedge clk); #1;

        // Random output backpressure over a longer job.
        start_job(5, 3);
        bp_en = 1'b1;
        send_beats(15, 0, 17, -1, st);
        wait_done("rand_bp");
        bp_en = 1'b0;
        @(posedge clk); #2 out_rdy = 1'b1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
